// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment scan display: segment width, the
// all-dark code, the hex glyph table and the digit-index width helper.
package disp_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-high {g..a} glyphs, entry n at bits [7n +: 7]
  localparam logic [16*SEG_W-1:0] HEX_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg_scan_display_hex7seg.sv
// Combinational hex-digit to active-high 7-segment glyph decoder.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0]       dig_i,
  output logic [SEG_W-1:0] seg_o
);
  assign seg_o = HEX_PAT[int'(dig_i)*SEG_W +: SEG_W];
endmodule

// File: rtl/seg_scan_display.sv
// Nibble history shifter driving a time-multiplexed common-anode display,
// with one dark cycle per digit slot and optional leading-zero blanking.
module seg_scan_display
  import disp_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       din,
  input  logic             din_valid,
  input  logic             freeze,
  input  logic             blank_lz,
  output logic [NDIG-1:0]  an,
  output logic [SEG_W-1:0] seg,
  output logic             dp
);
  localparam int IW = idx_w(NDIG);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int HW = 4 * NDIG;

  logic [HW-1:0]    hist_q, hist_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick;
  logic [3:0]       dig_sel;
  logic             dig_blank;
  logic [NDIG-1:0]  lz_mask;
  logic             zero_above;
  logic [SEG_W-1:0] glyph;

  assign tick = (pre_q == PW'(SCAN_DIV - 1));

  // Digit i is a leading zero when it and every more-significant digit are zero
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_above = zero_above && (hist_q[4*i +: 4] == 4'h0);
      lz_mask[i] = blank_lz && zero_above;
    end
  end

  always_comb begin
    dig_sel   = 4'h0;
    dig_blank = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        dig_sel   = hist_q[4*i +: 4];
        dig_blank = lz_mask[i];
      end
    end
  end

  hex7seg u_hex7seg (
    .dig_i (dig_sel),
    .seg_o (glyph)
  );

  always_comb begin
    hist_d = hist_q;
    pre_d  = pre_q + PW'(1);
    idx_d  = idx_q;
    an_d   = '1;
    seg_d  = SEG_OFF;
    dp_d   = 1'b1;
    if (din_valid && !freeze) begin
      hist_d = {hist_q[HW-5:0], din};
    end
    if (tick) begin
      pre_d = '0;
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      an_d  = ~(NDIG'(1) << idx_q);
      seg_d = dig_blank ? SEG_OFF : ~glyph;
      dp_d  = !(freeze && (idx_q == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      pre_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
    end else begin
      hist_q <= hist_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: cycle-count display model plus directed literal checks and a random phase.
module tb_seg_scan_display;
  localparam int NDIG = 4;
  localparam int SD   = 4;
  localparam bit [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = 4'h0;
  logic       din_valid = 1'b0;
  logic       freeze = 1'b0;
  logic       blank_lz = 1'b0;
  logic [NDIG-1:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int passed = 0;
  bit check_en = 1'b0;

  // Model state: digit values (0 = newest) and cycles since reset
  int dig [NDIG];
  int cnt = 0;
  logic [NDIG-1:0] exp_an;
  logic [6:0]      exp_seg;
  logic            exp_dp;

  seg_scan_display #(.NDIG(NDIG), .SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .freeze    (freeze),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_hist();
    logic [15:0] h;
    h = '0;
    for (int i = 0; i < NDIG; i++) h[4*i +: 4] = 4'(dig[i]);
    return h;
  endfunction

  always @(posedge clk) begin
    int pos, slot;
    bit all_zero;
    if (rst) begin
      exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1;
      for (int i = 0; i < NDIG; i++) dig[i] = 0;
      cnt = 0;
      check_en = 1'b1;
    end else begin
      pos  = cnt % SD;
      slot = (cnt / SD) % NDIG;
      if (pos == SD - 1) begin
        exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_an = ~(NDIG'(1) << slot);
        all_zero = 1'b1;
        for (int i = slot; i < NDIG; i++) if (dig[i] != 0) all_zero = 1'b0;
        exp_seg = (blank_lz && slot != 0 && all_zero) ? 7'h7F : ~PAT[dig[slot]];
        exp_dp = !(freeze && slot == 0);
      end
      if (din_valid && !freeze) begin
        for (int i = NDIG - 1; i > 0; i--) dig[i] = dig[i-1];
        dig[0] = int'(din);
      end
      cnt++;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if (an === exp_an && seg === exp_seg && dp === exp_dp) passed++;
      else $display("FAIL model t=%0t an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                    $time, an, seg, dp, exp_an, exp_seg, exp_dp);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s got=%h expected=%h", nm, act, expv);
  endtask

  task automatic wait_an(input logic [NDIG-1:0] want, input string nm);
    int n = 0;
    @(negedge clk);
    while (an !== want && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (an !== want) begin
      total++;
      $display("FAIL %s timeout an=%b expected=%b", nm, an, want);
    end
  endtask

  task automatic feed4(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      din = v[4*i +: 4];
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] scan_exp [16];
    scan_exp = '{4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,
                 4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7,4'hF};

    // Reset held for three edges
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_seg", 16'(seg), 16'h7F);
      chk("rst_dp", 16'(dp), 16'h1);
    end
    rst = 1'b0;

    // Scan timing over one frame
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("scan_an", 16'(an), 16'(scan_exp[i]));
      if (i == 0) chk("first_seg", 16'(seg), 16'h40);
    end

    feed4(16'h1234);
    chk("hist_1234", model_hist(), 16'h1234);
    wait_an(4'b1110, "w_d0"); chk("d0_4", 16'(seg), 16'h19);
    wait_an(4'b1101, "w_d1"); chk("d1_3", 16'(seg), 16'h30);
    wait_an(4'b1011, "w_d2"); chk("d2_2", 16'(seg), 16'h24);
    wait_an(4'b0111, "w_d3"); chk("d3_1", 16'(seg), 16'h79);

    feed4(16'h00A5);
    blank_lz = 1'b1;
    wait_an(4'b1110, "w_lz0"); chk("lz_d0", 16'(seg), 16'h12);
    wait_an(4'b1101, "w_lz1"); chk("lz_d1", 16'(seg), 16'h08);
    wait_an(4'b1011, "w_lz2"); chk("lz_d2", 16'(seg), 16'h7F);
    wait_an(4'b0111, "w_lz3"); chk("lz_d3", 16'(seg), 16'h7F);
    @(negedge clk);
    blank_lz = 1'b0;
    wait_an(4'b1011, "w_nlz2"); chk("nolz_d2", 16'(seg), 16'h40);
    wait_an(4'b0111, "w_nlz3"); chk("nolz_d3", 16'(seg), 16'h40);

    feed4(16'h1234);
    @(negedge clk);
    freeze = 1'b1; din_valid = 1'b1; din = 4'hF;
    repeat (8) @(negedge clk);
    wait_an(4'b1110, "w_fz0"); chk("fz_dp0", 16'(dp), 16'h0); chk("fz_seg0", 16'(seg), 16'h19);
    wait_an(4'b1101, "w_fz1"); chk("fz_dp1", 16'(dp), 16'h1);
    freeze = 1'b0; din_valid = 1'b0;
    chk("fz_hist", model_hist(), 16'h1234);
    @(negedge clk);
    din = 4'hF; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("hist_234F", model_hist(), 16'h234F);
    wait_an(4'b1110, "w_f0"); chk("d0_F", 16'(seg), 16'h0E);

    feed4(16'hBEEF);
    wait_an(4'b1011, "w_rs2"); chk("beef_d2", 16'(seg), 16'h06);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_an", 16'(an), 16'hF);
    chk("mr_seg", 16'(seg), 16'h7F);
    chk("mr_hist", model_hist(), 16'h0);
    @(negedge clk);
    chk("mr_an1", 16'(an), 16'hE);
    chk("mr_seg1", 16'(seg), 16'h40);

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      din       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      din_valid = 1'($urandom_range(0, 1));
      freeze    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      rst       = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; freeze = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream consumer of the 4-bit `dout` stream from `top`.
- Each accepted nibble is shifted into an NDIG-digit history.
- The history is shown on a time-multiplexed, common-anode 7-segment display, with the newest nibble on digit 0 (rightmost).
- The block is the board-facing output stage that makes the counter stream visible.

Parameters:
- NDIG, 4: number of display digits (2..8).
- SCAN_DIV, 1000: clk cycles per digit slot, including one blank cycle (must be >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  4  nibble from upstream stage.
- din_valid  in  1  din qualifier; one sample accepted per cycle when high.
- freeze  in  1  1 = ignore din_valid and hold history.
- blank_lz  in  1  1 = blank leading-zero digits.
- an  out  NDIG  digit enables, active-low; bit i = digit i.
- seg  out  7  segments, active-low, order {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high; ports are named clk and rst.
- All state is updated on the rising clk edge only. There is no asynchronous path.
- Reset values (rst=1 at an edge):
  - hist=0, pre=0, idx=0.
  - an=all 1, seg=7'h7F, dp=1 (display dark).
- History, stored as hist[4*NDIG-1:0]:
  - If din_valid && !freeze: hist <= {hist[4*NDIG-5:0], din}. Digit 0 = hist[3:0] = newest sample; the oldest nibble falls off.
  - If freeze=1: din_valid is ignored and the sample is dropped, not queued.
- Prescaler:
  - tick = (pre == SCAN_DIV-1).
  - On tick: pre <= 0 and idx <= (idx == NDIG-1) ? 0 : idx+1.
  - Otherwise: pre <= pre+1.
- Output register (an/seg/dp are flops, updated every non-reset edge from pre-edge state):
  - If tick: an=all 1, seg=7'h7F, dp=1. This is the anti-ghosting blank cycle.
  - Else: an=~(1<<idx); seg=~pattern(hist digit idx), or 7'h7F if that digit is lz-blanked; dp=0 only when freeze=1 && idx==0, else 1.
  - Each digit is therefore lit for SCAN_DIV-1 cycles and dark for 1 cycle per slot. Full frame = NDIG*SCAN_DIV cycles.
- Latency:
  - A sample accepted at edge k is visible on seg from edge k+1, provided its digit is selected and the cycle is not a tick.
  - A history shift during a lit slot changes seg mid-slot; this is intended.
- Leading-zero blanking: digit i (i != 0) is blanked when blank_lz=1 and digits i..NDIG-1 are all zero. Digit 0 is never blanked.
- Pattern (active-high, {g..a}):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Reset mid-frame: the next edge forces the reset values and the scan restarts at digit 0, slot position 0.
- Simultaneous events: a shift and a tick in the same cycle are both performed; the blank output is unaffected by the shift.

Decomposition:
- Shared package `disp_pkg`:
  - SEG_W=7 and SEG_OFF=7'h7F.
  - Digit-index width function (clog2 of NDIG).
  - The 16-entry hex pattern constant.
- Sub-module `hex7seg`: combinational 4-bit to 7-bit active-high pattern decoder. It is instantiated once, on the muxed digit.
- The top of this block holds the history shifter, prescaler, lz-blank logic and output register.

Test Plan (NDIG=4, SCAN_DIV=4 unless stated):
1. Hold rst=1 for 3 edges -> an=4'hF, seg=7'h7F, dp=1 throughout. After release, edge 1 gives an=4'b1110, seg=7'h40 (digit "0").
2. Scan timing, no input -> an cycles 1110 x3, 1111 x1, 1101 x3, 1111, 1011 x3, 1111, 0111 x3, 1111, then repeats. Frame period is 16 cycles.
3. Feed din 1,2,3,4 with din_valid in 4 consecutive cycles -> hist=16'h1234. Lit seg values: digit0=7'h19 ("4"), d1=7'h30 ("3"), d2=7'h24 ("2"), d3=7'h79 ("1").
4. Load 16'h00A5 then set blank_lz=1 -> d0=7'h12, d1=7'h08, d2 and d3 seg=7'h7F while their an bit is low. With blank_lz=0, d2 and d3 show 7'h40.
5. freeze=1 with din_valid=1 and din=F for 8 cycles -> hist is unchanged and dp=0 only while an=1110. After freeze=0, one din=F gives hist=16'h234F.
6. Assert rst for one edge while idx=2 and hist=16'hBEEF -> next edge all dark and hist=0. The scan resumes with 1110 on the following edge.
